// File: rtl/data_cache_if.sv
// CPU-side request/response and line-wide backing-memory signals of the data cache.
// The cache takes the slave view; the CPU/memory environment takes the master view.
interface data_cache_if;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  din;
  logic         is_ready;
  logic         is_output_valid;
  logic [31:0]  dout;
  logic         is_hit;
  logic         dmem_req;
  logic         dmem_we;
  logic [31:0]  dmem_addr;
  logic [127:0] dmem_wdata;
  logic         dmem_ack;
  logic [127:0] dmem_rdata;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  modport master (
    output is_input_valid, addr, mem_read, mem_write, din, dmem_ack, dmem_rdata,
    input  is_ready, is_output_valid, dout, is_hit, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  hit_count, miss_count
  );

  modport slave (
    input  is_input_valid, addr, mem_read, mem_write, din, dmem_ack, dmem_rdata,
    output is_ready, is_output_valid, dout, is_hit, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output hit_count, miss_count
  );
endinterface

// File: rtl/data_cache.sv
// Blocking direct-mapped write-back/write-allocate data cache with 16-byte lines,
// refilled through a req/ack line-wide backing-memory handshake.
module data_cache #(
  parameter int unsigned NUM_SETS = 16
) (
  input logic        clk,
  input logic        reset,
  data_cache_if.slave bus
);
  localparam int unsigned INDEX_BITS = $clog2(NUM_SETS);
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned TAG_BITS   = 32 - 4 - INDEX_BITS;

  typedef enum logic [1:0] {StIdle, StTag, StWriteback, StAllocate} state_e;

  state_e state_q, state_d;

  logic [31:2]         req_addr_q;
  logic [31:0]         req_din_q;
  logic                req_write_q;
  logic                miss_q;
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_BITS-1:0] tag_q  [NUM_SETS];
  logic [127:0]        data_q [NUM_SETS];
  logic [31:0]         hit_count_q, miss_count_q;

  logic [INDEX_BITS-1:0] idx;
  logic [1:0]            off;
  logic [TAG_BITS-1:0]   req_tag;
  logic [127:0]          line;
  logic [31:0]           cur_word;
  logic                  lookup_hit;
  logic                  accept;

  assign idx        = req_addr_q[4 +: INDEX_BITS];
  assign off        = req_addr_q[3:2];
  assign req_tag    = req_addr_q[31 -: TAG_BITS];
  assign line       = data_q[idx];
  assign cur_word   = line[{off, 5'b0} +: 32];
  assign lookup_hit = valid_q[idx] && (tag_q[idx] == req_tag);
  assign accept     = (state_q == StIdle) && bus.is_input_valid && (bus.mem_read || bus.mem_write);

  logic         is_ready, is_output_valid, is_hit, dmem_req, dmem_we;
  logic [31:0]  dout, dmem_addr;
  logic [127:0] dmem_wdata;

  always_comb begin
    state_d         = state_q;
    is_ready        = 1'b0;
    is_output_valid = 1'b0;
    is_hit          = 1'b0;
    dout            = '0;
    dmem_req        = 1'b0;
    dmem_we         = 1'b0;
    dmem_addr       = '0;
    dmem_wdata      = '0;
    case (state_q)
      StIdle: begin
        is_ready = 1'b1;
        if (accept) state_d = StTag;
      end
      StTag: begin
        if (lookup_hit) begin
          is_output_valid = 1'b1;
          is_hit          = ~miss_q;
          dout            = req_write_q ? req_din_q : cur_word;
          state_d         = StIdle;
        end else if (valid_q[idx] && dirty_q[idx]) begin
          state_d = StWriteback;
        end else begin
          state_d = StAllocate;
        end
      end
      StWriteback: begin
        dmem_req   = 1'b1;
        dmem_we    = 1'b1;
        dmem_addr  = {tag_q[idx], idx, 4'b0};
        dmem_wdata = line;
        if (bus.dmem_ack) state_d = StAllocate;
      end
      StAllocate: begin
        dmem_req  = 1'b1;
        dmem_addr = {req_tag, idx, 4'b0};
        if (bus.dmem_ack) state_d = StTag;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      req_addr_q   <= '0;
      req_din_q    <= '0;
      req_write_q  <= 1'b0;
      miss_q       <= 1'b0;
      valid_q      <= '0;
      dirty_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_addr_q  <= bus.addr[31:2];
        req_din_q   <= bus.din;
        req_write_q <= bus.mem_write;
        miss_q      <= 1'b0;
      end
      case (state_q)
        StTag: begin
          if (lookup_hit) begin
            if (req_write_q) dirty_q[idx] <= 1'b1;
            // Counters saturate rather than wrap
            if (!miss_q) begin
              if (~&hit_count_q) hit_count_q <= hit_count_q + 32'd1;
            end else begin
              if (~&miss_count_q) miss_count_q <= miss_count_q + 32'd1;
            end
          end else begin
            miss_q <= 1'b1;
          end
        end
        StWriteback: if (bus.dmem_ack) dirty_q[idx] <= 1'b0;
        StAllocate: begin
          if (bus.dmem_ack) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == StTag && lookup_hit && req_write_q) begin
        data_q[idx][{off, 5'b0} +: 32] <= req_din_q;
      end
      if (state_q == StAllocate && bus.dmem_ack) begin
        data_q[idx] <= bus.dmem_rdata;
        tag_q[idx]  <= req_tag;
      end
    end
  end

  assign bus.is_ready        = is_ready;
  assign bus.is_output_valid = is_output_valid;
  assign bus.is_hit          = is_hit;
  assign bus.dout            = dout;
  assign bus.dmem_req        = dmem_req;
  assign bus.dmem_we         = dmem_we;
  assign bus.dmem_addr       = dmem_addr;
  assign bus.dmem_wdata      = dmem_wdata;
  assign bus.hit_count       = hit_count_q;
  assign bus.miss_count      = miss_count_q;
endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: directed CPU requests with expected completions and
// expected backing-memory transactions queued up front, checked by independent monitors.
module tb_data_cache;
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_cache_if bus();

  data_cache #(.NUM_SETS(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] dout;
    logic        hit;
  } resp_t;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    int           delay;
  } mem_t;

  resp_t resp_q[$];
  mem_t  mem_q[$];

  int checks;
  int failures;
  int done_cnt;
  int exp_hits;
  int exp_misses;
  int spurious_req;
  int spurious_sent;

  initial begin
    checks = 0; failures = 0; done_cnt = 0; exp_hits = 0; exp_misses = 0;
    spurious_req = 0; spurious_sent = 0;
  end

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic we, input logic [31:0] a, input logic [127:0] wdata,
                          input logic [127:0] rdata, input int delay);
    mem_t m;
    m.we = we; m.addr = a; m.wdata = wdata; m.rdata = rdata; m.delay = delay;
    mem_q.push_back(m);
  endtask

  // Completion monitor: pops the scoreboard whenever the DUT signals a result
  initial begin : monitor
    resp_t r;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 && bus.is_output_valid === 1'b1) begin
        if (resp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output: got dout %0h expected no completion", bus.dout);
        end else begin
          r = resp_q.pop_front();
          check("dout", bus.dout, r.dout);
          check("is_hit", bus.is_hit, r.hit);
        end
        done_cnt++;
      end
    end
  end

  // Backing-memory model: checks each request against the expected queue, checks the
  // request stays stable until ack, and acks after the programmed delay.
  initial begin : mem_model
    mem_t         cur;
    bit           in_txn;
    bit           check_drop;
    int           cnt;
    logic         we_s;
    logic [31:0]  addr_s;
    logic [127:0] wdata_s;
    in_txn = 0; check_drop = 0; cnt = 0;
    cur.we = 0; cur.addr = '0; cur.wdata = '0; cur.rdata = '0; cur.delay = 1;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        in_txn = 0; check_drop = 0;
        continue;
      end
      if (check_drop) begin
        check_drop = 0;
        check("dmem_req_drop", bus.dmem_req, 1'b0);
      end
      if (spurious_sent < spurious_req && bus.dmem_req !== 1'b1) begin
        bus.dmem_rdata = '1;
        bus.dmem_ack = 1'b1;
        @(posedge clk);
        #1 bus.dmem_ack = 1'b0;
        spurious_sent++;
        continue;
      end
      if (bus.dmem_req !== 1'b1) begin
        in_txn = 0;
        continue;
      end
      if (!in_txn) begin
        in_txn = 1; cnt = 0;
        we_s = bus.dmem_we; addr_s = bus.dmem_addr; wdata_s = bus.dmem_wdata;
        if (mem_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_dmem_req: got addr %0h we %0b expected no request",
                   bus.dmem_addr, bus.dmem_we);
          cur.we = bus.dmem_we; cur.rdata = '0; cur.delay = 1;
        end else begin
          cur = mem_q.pop_front();
          check("dmem_we", bus.dmem_we, cur.we);
          check("dmem_addr", bus.dmem_addr, cur.addr);
          if (cur.we) check("dmem_wdata", bus.dmem_wdata, cur.wdata);
        end
      end else begin
        check("dmem_stable", {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata},
              {we_s, addr_s, wdata_s});
      end
      cnt++;
      if (cnt >= cur.delay) begin
        bus.dmem_rdata = cur.rdata;
        bus.dmem_ack = 1'b1;
        @(posedge clk);
        #1 bus.dmem_ack = 1'b0;
        in_txn = 0;
        // A write-back is followed directly by the fill request, so only fills drop req
        check_drop = !cur.we;
      end
    end
  end

  task automatic cpu_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_dout, input logic exp_hit);
    int    n;
    int    start;
    resp_t r;
    n = 0;
    @(negedge clk);
    while (bus.is_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL ready_timeout: got is_ready %0b expected 1", bus.is_ready);
    end
    r.dout = exp_dout; r.hit = exp_hit;
    resp_q.push_back(r);
    if (exp_hit) exp_hits++; else exp_misses++;
    start = done_cnt;
    bus.is_input_valid = 1'b1; bus.addr = a; bus.din = d;
    bus.mem_write = wr; bus.mem_read = !wr;
    @(posedge clk);
    #1 bus.is_input_valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    if (exp_hit) begin
      @(negedge clk);
      check("hit_latency", bus.is_output_valid, 1'b1);
    end
    n = 0;
    while (done_cnt == start && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == start) begin
      checks++; failures++;
      $display("FAIL completion_timeout: got no completion expected one for addr %0h", a);
    end
  endtask

  localparam logic [127:0] L0  = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] L0W = {32'd4, 32'hDEADBEEF, 32'd2, 32'd1};
  localparam logic [127:0] L1  = {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000};
  localparam logic [127:0] LX  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] LXW = {32'hA3, 32'hA2, 32'hCAFEF00D, 32'hA0};
  localparam logic [127:0] LY  = {32'hB3, 32'hB2, 32'hB1, 32'hB0};

  initial begin : stimulus
    int n;
    bus.is_input_valid = 1'b0; bus.addr = '0; bus.din = '0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_is_ready", bus.is_ready, 1'b1);
    check("rst_out_valid", bus.is_output_valid, 1'b0);
    check("rst_is_hit", bus.is_hit, 1'b0);
    check("rst_dout", bus.dout, 32'h0);
    check("rst_dmem_req", bus.dmem_req, 1'b0);
    check("rst_dmem_we", bus.dmem_we, 1'b0);
    check("rst_dmem_addr", bus.dmem_addr, 32'h0);
    check("rst_dmem_wdata", bus.dmem_wdata, 128'h0);
    check("rst_hit_count", bus.hit_count, 32'h0);
    check("rst_miss_count", bus.miss_count, 32'h0);

    // Cold miss then hits, write hit
    push_mem(1'b0, 32'h0, '0, L0, 1);
    cpu_req(1'b0, 32'h0, 32'h0, 32'h1, 1'b0);
    cpu_req(1'b0, 32'h4, 32'h0, 32'h2, 1'b1);
    cpu_req(1'b1, 32'h8, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
    cpu_req(1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b1);

    // Dirty eviction of index 0, fill acked after 10 cycles
    push_mem(1'b1, 32'h0, L0W, '0, 1);
    push_mem(1'b0, 32'h100, '0, L1, 10);
    cpu_req(1'b0, 32'h100, 32'h0, 32'h1111_0000, 1'b0);

    // Clean eviction back to line 0
    push_mem(1'b0, 32'h0, '0, L0W, 10);
    cpu_req(1'b0, 32'h0, 32'h0, 32'h1, 1'b0);
    cpu_req(1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b1);

    // Write miss allocates, then dirty eviction of index 1
    push_mem(1'b0, 32'h210, '0, LX, 3);
    cpu_req(1'b1, 32'h214, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
    cpu_req(1'b0, 32'h214, 32'h0, 32'hCAFEF00D, 1'b1);
    push_mem(1'b1, 32'h210, LXW, '0, 2);
    push_mem(1'b0, 32'h1210, '0, LY, 1);
    cpu_req(1'b0, 32'h1218, 32'h0, 32'hB2, 1'b0);

    repeat (2) @(negedge clk);
    check("hit_count", bus.hit_count, exp_hits);
    check("miss_count", bus.miss_count, exp_misses);
    check("mem_q_drained", mem_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);

    // Spurious ack while idle must change nothing
    spurious_req++;
    repeat (4) @(negedge clk);
    check("spurious_is_ready", bus.is_ready, 1'b1);
    check("spurious_dmem_req", bus.dmem_req, 1'b0);
    check("spurious_hit_count", bus.hit_count, exp_hits);
    check("spurious_miss_count", bus.miss_count, exp_misses);

    // Reset while the fill is outstanding
    push_mem(1'b0, 32'h40, '0, '0, 1000);
    @(negedge clk);
    bus.is_input_valid = 1'b1; bus.addr = 32'h40; bus.mem_read = 1'b1;
    @(posedge clk);
    #1 bus.is_input_valid = 1'b0; bus.mem_read = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.dmem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fill_started", bus.dmem_req, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_hits = 0; exp_misses = 0;
    @(negedge clk);
    check("midrst_dmem_req", bus.dmem_req, 1'b0);
    check("midrst_is_ready", bus.is_ready, 1'b1);
    check("midrst_hit_count", bus.hit_count, 32'h0);
    check("midrst_miss_count", bus.miss_count, 32'h0);

    push_mem(1'b0, 32'h0, '0, L0, 2);
    cpu_req(1'b0, 32'h4, 32'h0, 32'h2, 1'b0);
    repeat (2) @(negedge clk);
    check("post_rst_hit_count", bus.hit_count, exp_hits);
    check("post_rst_miss_count", bus.miss_count, exp_misses);
    check("final_mem_q", mem_q.size(), 0);
    check("final_resp_q", resp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test expected finish within 20000 cycles");
    $fatal(1, "watchdog expired");
  end
endmodule
